// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  localparam int CNT_W = 4;
  localparam int LANES = 4;
endpackage

// File: rtl/dmem_sram_bytes.sv
// dmem_sram_bytes: 2^ADDR_W x 32 array, per-lane synchronous write, combinational read of the same port.
module dmem_sram_bytes
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LANES-1:0]  we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    for (int i = 0; i < LANES; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: M-stage data-memory responder with fixed wait states and a byte-lane RAM.
// Defining DMEM_ERR_EN flags out-of-range addresses via err instead of wrapping them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic l_we, l_oor, oor_in, accept, unused_addr;
  logic [ADDR_W-1:0] l_idx;
  logic [31:0] l_wdata, ram_q;
  logic [LANES-1:0] l_be;
  assign accept = state == IDLE && req;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
`ifdef DMEM_ERR_EN
  assign oor_in = |addr[31:ADDR_W+2];
  assign err = ack && l_oor;
`else
  assign oor_in = 1'b0;
  assign err = 1'b0;
`endif
  // ack and busy are gated by reset so an abort in ACCESS never reports completion
  assign ack = reset && state == ACCESS;
  assign busy = reset && state != IDLE;
  always_comb begin
    state_nx = state == IDLE ? (req ? (WAIT_CYCLES == 0 ? ACCESS : WAIT) : IDLE)
             : state == WAIT ? (cnt == CNT_W'(1) ? ACCESS : WAIT)
             : IDLE;
    cnt_nx = accept ? CNT_W'(WAIT_CYCLES) : state == WAIT ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (ack && !l_we) rdata <= l_oor ? '0 : ram_q;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      l_we    <= we;
      l_idx   <= addr[ADDR_W+1:2];
      l_wdata <= wdata;
      l_be    <= byte_en;
      l_oor   <= oor_in;
    end
  end
  dmem_sram_bytes #(.ADDR_W(ADDR_W)) u_sram (
    .clk   (clk),
    .addr  (l_idx),
    .we    (ack && l_we && !l_oor ? l_be : '0),
    .wdata (l_wdata),
    .rdata (ram_q)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus random checks of two responders (2 and 0 wait states) against a word-array model.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic [1:0] req, we, ack, busy, err;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [3:0] be [2];
  logic [31:0] m [2][32];
  int checks = 0;
  int errors = 0;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .byte_en(be[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0])
  );
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .byte_en(be[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic xact(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic [31:0] rd, output logic e);
    int n = 0;
    req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d; be[u] = b;
    do begin
      step();
      n++;
      if (n == 1) chk("busy_active", 32'(busy[u]), 32'd1);
    end while (!ack[u] && n < 20);
    chk(u == 1 ? "latency_w0" : "latency_w2", n, u == 1 ? 32'd1 : 32'd3);
    e = err[u];
    req[u] = 1'b0;
    step();
    rd = rdata[u];
    chk("ack_single_pulse", 32'(ack[u]), 32'd0);
    chk("busy_done", 32'(busy[u]), 32'd0);
  endtask

  task automatic wr(input int u, input int idx, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] prev, rd;
    logic e;
    prev = rdata[u];
    xact(u, 1'b1, 32'(idx) * 4 + $urandom_range(0, 3), d, b, rd, e);
    m[u][idx] = merge(m[u][idx], d, b);
    chk("write_keeps_rdata", rd, prev);
    chk("write_err", 32'(e), 32'd0);
  endtask

  task automatic rd_chk(input int u, input int idx, input string tag);
    logic [31:0] rd;
    logic e;
    xact(u, 1'b0, 32'(idx) * 4 + $urandom_range(0, 3), $urandom, 4'($urandom), rd, e);
    chk(tag, rd, m[u][idx]);
  endtask

  initial begin
    logic [31:0] rd;
    logic e;
    int n;
    reset = 1'b0;
    req = '0; we = '0;
    for (int u = 0; u < 2; u++) begin addr[u] = '0; wdata[u] = '0; be[u] = '0; end
    step();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0; wdata[0] = 32'hA5A5_0000; be[0] = 4'hF;
    req[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_ack", 32'(ack[0]), 32'd0);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_rdata", rdata[0], 32'd0);
      chk("rst_ack_w0", 32'(ack[1]), 32'd0);
    end
    req[1] = 1'b0;
    reset = 1'b1;
    n = 0;
    do begin step(); n++; end while (!ack[0] && n < 20);
    chk("rst_release_latency", n, 32'd3);
    m[0][0] = 32'hA5A5_0000;
    req[0] = 1'b0;
    step();
    step();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 32; i++) wr(u, i, $urandom, 4'hF);
    wr(0, 16, 32'hDEAD_BEEF, 4'hF);
    xact(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, e);
    chk("read_full_word", rd, 32'hDEAD_BEEF);
    wr(0, 16, 32'h1122_3344, 4'b0101);
    xact(0, 1'b0, 32'h40, 32'h0, 4'hF, rd, e);
    chk("read_lane_merge", rd, 32'hDE22_BE44);
    wr(0, 16, 32'hFFFF_FFFF, 4'b0000);
    rd_chk(0, 16, "byte_en_zero_noop");
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h55; be[0] = 4'hF;
    step();
    chk("mid_wait_busy", 32'(busy[0]), 32'd1);
    reset = 1'b0; req[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("mid_wait_no_ack", 32'(ack[0]), 32'd0);
      step();
    end
    reset = 1'b1;
    rd_chk(0, 4, "mid_wait_write_dropped");
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h14; wdata[0] = 32'hCAFE_F00D; be[0] = 4'hF;
    step(); step(); step();
    chk("access_ack_before_reset", 32'(ack[0]), 32'd1);
    reset = 1'b0; req[0] = 1'b0;
    #1;
    chk("access_ack_gated", 32'(ack[0]), 32'd0);
    step();
    reset = 1'b1;
    rd_chk(0, 5, "access_write_dropped");
`ifdef DMEM_ERR_EN
    xact(0, 1'b1, 32'h0001_0000, 32'h1234_5678, 4'hF, rd, e);
    chk("oor_write_err", 32'(e), 32'd1);
    rd_chk(0, 0, "oor_write_suppressed");
    xact(0, 1'b0, 32'h0001_0000, 32'h0, 4'hF, rd, e);
    chk("oor_read_err", 32'(e), 32'd1);
    chk("oor_read_zero", rd, 32'd0);
`else
    xact(0, 1'b1, 32'h0001_0000, 32'h1234_5678, 4'hF, rd, e);
    chk("wrap_write_err", 32'(e), 32'd0);
    m[0][0] = 32'h1234_5678;
    rd_chk(0, 0, "wrap_write_word0");
`endif
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("b2b_ack", 32'(ack[1]), 32'(k % 2));
      if (k % 2 == 0) chk("b2b_rdata", rdata[1], m[1][k/2-1]);
      if (k == 1) addr[1] = 32'h4;
      if (k == 3) addr[1] = 32'h8;
      if (k == 5) req[1] = 1'b0;
    end
    step();
    for (int k = 0; k < 60; k++) begin
      int u, idx;
      u = int'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) wr(u, idx, $urandom, 4'($urandom));
      else rd_chk(u, idx, "random_read");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
